// File: rtl/fetch_pc_unit.sv
// Instruction-fetch program counter with a start/run/halt sequencer and a
// saturating run-cycle counter.
module fetch_pc_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             done_in,
  input  logic             reljump_enable,
  input  logic             absjump_enable,
  input  logic             compare_enable,
  input  logic             cmp_equal,
  input  logic [OFF_W-1:0] jump_operand,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  logic [PC_W-1:0] abs_target;
  logic [PC_W-1:0] rel_offset;
  logic [PC_W-1:0] pc_next_run;
  logic            rel_taken;

  // A wide operand is cut to the PC width; a narrow one is zero-extended for
  // absolute targets and sign-extended for relative offsets.
  generate
    if (OFF_W >= PC_W) begin : g_wide_operand
      assign abs_target = jump_operand[PC_W-1:0];
      assign rel_offset = jump_operand[PC_W-1:0];
    end else begin : g_narrow_operand
      assign abs_target = {{(PC_W-OFF_W){1'b0}}, jump_operand};
      assign rel_offset = {{(PC_W-OFF_W){jump_operand[OFF_W-1]}}, jump_operand};
    end
  endgenerate

  assign rel_taken = reljump_enable && (!compare_enable || cmp_equal);

  always_comb begin
    pc_next_run = pc + PC_W'(1);
    if (absjump_enable) begin
      pc_next_run = abs_target;
    end else if (rel_taken) begin
      pc_next_run = pc + rel_offset;
    end
  end

  // Halt takes priority over any jump presented in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      running     <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RUN;
            running     <= 1'b1;
            halted      <= 1'b0;
            pc          <= start_addr;
            cycle_count <= '0;
          end
        end
        RUN: begin
          if (cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
          if (done_in) begin
            state   <= HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else begin
            pc <= pc_next_run;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scoreboard bench for fetch_pc_unit, with a second narrow-counter
// instance sharing the stimulus to exercise counter saturation.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  start_addr;
  logic        done_in;
  logic        reljump_enable;
  logic        absjump_enable;
  logic        compare_enable;
  logic        cmp_equal;
  logic [7:0]  jump_operand;
  logic [9:0]  pc;
  logic        running;
  logic        halted;
  logic [15:0] cycle_count;
  logic [9:0]  pc_s;
  logic        running_s;
  logic        halted_s;
  logic [3:0]  cycle_count_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [9:0]  pc;
    logic        running;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  fetch_pc_unit #(.PC_W(10), .OFF_W(8), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .done_in        (done_in),
    .reljump_enable (reljump_enable),
    .absjump_enable (absjump_enable),
    .compare_enable (compare_enable),
    .cmp_equal      (cmp_equal),
    .jump_operand   (jump_operand),
    .pc             (pc),
    .running        (running),
    .halted         (halted),
    .cycle_count    (cycle_count)
  );

  fetch_pc_unit #(.PC_W(10), .OFF_W(8), .CNT_W(4)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .done_in        (done_in),
    .reljump_enable (reljump_enable),
    .absjump_enable (absjump_enable),
    .compare_enable (compare_enable),
    .cmp_equal      (cmp_equal),
    .jump_operand   (jump_operand),
    .pc             (pc_s),
    .running        (running_s),
    .halted         (halted_s),
    .cycle_count    (cycle_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (pc === e.pc) else begin
        errors++;
        $error("[TB] FAIL %s pc: observed %h expected %h", e.tag, pc, e.pc);
      end
      checks++;
      assert (running === e.running) else begin
        errors++;
        $error("[TB] FAIL %s running: observed %b expected %b", e.tag, running, e.running);
      end
      checks++;
      assert (halted === e.halted) else begin
        errors++;
        $error("[TB] FAIL %s halted: observed %b expected %b", e.tag, halted, e.halted);
      end
      checks++;
      assert (cycle_count === e.cnt) else begin
        errors++;
        $error("[TB] FAIL %s cycle_count: observed %h expected %h", e.tag, cycle_count, e.cnt);
      end
    end
  endtask

  task automatic push_expect(input string tag, input logic [9:0] epc, input logic er,
                             input logic eh, input logic [15:0] ecnt);
    exp_t e;
    e.tag = tag;
    e.pc = epc;
    e.running = er;
    e.halted = eh;
    e.cnt = ecnt;
    sb.push_back(e);
  endtask

  // One clock edge with the currently driven inputs, then compare
  task automatic apply_stimulus(input string tag, input logic [9:0] epc, input logic er,
                                input logic eh, input logic [15:0] ecnt);
    push_expect(tag, epc, er, eh, ecnt);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic check_sat(input logic [3:0] ecnt);
    checks++;
    assert (cycle_count_s === ecnt) else begin
      errors++;
      $error("[TB] FAIL sat_count: observed %h expected %h", cycle_count_s, ecnt);
    end
  endtask

  task automatic set_ctrl(input logic d, input logic rel, input logic abs_j,
                          input logic ce, input logic eq, input logic [7:0] op);
    done_in = d;
    reljump_enable = rel;
    absjump_enable = abs_j;
    compare_enable = ce;
    cmp_equal = eq;
    jump_operand = op;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    set_ctrl(0, 0, 0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    push_expect("reset", 10'h000, 0, 0, 16'd0);
    check_output();
    reset = 1'b0;

    $display("[TB] run up to pc=055 then asynchronous reset");
    start = 1'b1; start_addr = 10'h04E;
    apply_stimulus("start_04e", 10'h04E, 1, 0, 16'd0);
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      apply_stimulus("seq_pre_reset", 10'(10'h04E + i), 1, 0, 16'(i));
    end
    #2;
    reset = 1'b1;
    #1;
    push_expect("async_reset", 10'h000, 0, 0, 16'd0);
    check_output();
    reset = 1'b0;
    check_sat(4'd0);

    $display("[TB] sequential run and done");
    start = 1'b1; start_addr = 10'h010;
    apply_stimulus("start_010", 10'h010, 1, 0, 16'd0);
    start = 1'b0;
    apply_stimulus("seq1", 10'h011, 1, 0, 16'd1);
    apply_stimulus("seq2", 10'h012, 1, 0, 16'd2);
    apply_stimulus("seq3", 10'h013, 1, 0, 16'd3);
    set_ctrl(1, 0, 0, 0, 0, 8'h00);
    apply_stimulus("done", 10'h013, 0, 1, 16'd4);
    set_ctrl(0, 0, 0, 0, 0, 8'h00);
    apply_stimulus("halt_hold", 10'h013, 0, 1, 16'd4);

    $display("[TB] relative jumps");
    start = 1'b1; start_addr = 10'h020;
    apply_stimulus("start_020", 10'h020, 1, 0, 16'd0);
    start = 1'b0;
    set_ctrl(0, 1, 0, 0, 0, 8'hFC);
    apply_stimulus("rel_minus4", 10'h01C, 1, 0, 16'd1);
    set_ctrl(0, 0, 1, 0, 0, 8'h00);
    apply_stimulus("abs_zero", 10'h000, 1, 0, 16'd2);
    set_ctrl(0, 1, 0, 0, 0, 8'hFC);
    apply_stimulus("rel_wrap_low", 10'h3FC, 1, 0, 16'd3);
    set_ctrl(0, 1, 0, 0, 0, 8'h00);
    apply_stimulus("rel_self", 10'h3FC, 1, 0, 16'd4);
    set_ctrl(1, 0, 0, 0, 0, 8'h00);
    apply_stimulus("done2", 10'h3FC, 0, 1, 16'd5);
    set_ctrl(0, 0, 0, 0, 0, 8'h00);
    start = 1'b1; start_addr = 10'h3FE;
    apply_stimulus("start_3fe", 10'h3FE, 1, 0, 16'd0);
    start = 1'b0;
    set_ctrl(0, 1, 0, 0, 0, 8'h05);
    apply_stimulus("rel_wrap_high", 10'h003, 1, 0, 16'd1);
    set_ctrl(0, 0, 0, 0, 0, 8'h00);
    start = 1'b1; start_addr = 10'h100;
    apply_stimulus("start_in_run", 10'h004, 1, 0, 16'd2);
    start = 1'b0;

    $display("[TB] conditional branches");
    set_ctrl(0, 0, 1, 0, 0, 8'h30);
    apply_stimulus("abs_030", 10'h030, 1, 0, 16'd3);
    set_ctrl(0, 1, 0, 1, 0, 8'h08);
    apply_stimulus("branch_not_taken", 10'h031, 1, 0, 16'd4);
    set_ctrl(0, 0, 1, 0, 0, 8'h30);
    apply_stimulus("abs_030_again", 10'h030, 1, 0, 16'd5);
    set_ctrl(0, 1, 0, 1, 1, 8'h08);
    apply_stimulus("branch_taken", 10'h038, 1, 0, 16'd6);
    set_ctrl(0, 0, 0, 1, 1, 8'h08);
    apply_stimulus("compare_only", 10'h039, 1, 0, 16'd7);

    $display("[TB] absolute jumps and priority");
    set_ctrl(0, 0, 1, 0, 0, 8'hA7);
    apply_stimulus("abs_0a7", 10'h0A7, 1, 0, 16'd8);
    set_ctrl(0, 1, 1, 0, 0, 8'h05);
    apply_stimulus("abs_over_rel", 10'h005, 1, 0, 16'd9);
    set_ctrl(1, 0, 1, 0, 0, 8'h77);
    apply_stimulus("done_over_abs", 10'h005, 0, 1, 16'd10);
    set_ctrl(0, 1, 0, 0, 0, 8'h10);
    apply_stimulus("rel_in_halt", 10'h005, 0, 1, 16'd10);
    set_ctrl(0, 0, 1, 0, 0, 8'h44);
    apply_stimulus("abs_in_halt", 10'h005, 0, 1, 16'd10);
    set_ctrl(0, 0, 0, 0, 0, 8'h00);

    $display("[TB] sequential wrap and counter saturation");
    start = 1'b1; start_addr = 10'h3FF;
    apply_stimulus("start_3ff", 10'h3FF, 1, 0, 16'd0);
    start = 1'b0;
    apply_stimulus("seq_wrap", 10'h000, 1, 0, 16'd1);
    set_ctrl(1, 0, 0, 0, 0, 8'h00);
    apply_stimulus("done3", 10'h000, 0, 1, 16'd2);
    set_ctrl(0, 0, 0, 0, 0, 8'h00);
    start = 1'b1; start_addr = 10'h000;
    apply_stimulus("start_sat", 10'h000, 1, 0, 16'd0);
    start = 1'b0;
    check_sat(4'd0);
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus("sat_run", 10'(i), 1, 0, 16'(i));
      check_sat((i > 15) ? 4'hF : 4'(i));
    end

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: observed %0d entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control block.
- Holds the program counter and drives the instruction-memory address.
- Sequences program start/halt with a small FSM.
- Applies the relative, absolute and conditional jump requests plus the done request, all returned combinationally by control for the instruction currently at `pc`.
- Keeps a saturating run-cycle counter for the test harness.

Parameters:
- PC_W, 10, program counter / instruction address width in bits
- OFF_W, 8, width of jump operand (signed offset for relative jumps, unsigned target for absolute jumps)
- CNT_W, 16, width of the run-cycle counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  level/pulse; begins a program run from start_addr when not running
- start_addr  input  PC_W  first instruction address, sampled on accepted start
- done_in  input  1  halt request from control for current instruction
- reljump_enable  input  1  relative jump request from control
- absjump_enable  input  1  absolute jump request from control
- compare_enable  input  1  jump is conditional on cmp_equal
- cmp_equal  input  1  ALU equality result for current instruction
- jump_operand  input  OFF_W  jump offset/target (accumulator value)
- pc  output  PC_W  registered program counter = instruction-memory address
- running  output  1  FSM in RUN; control outputs honoured only while high
- halted  output  1  program finished; held until next accepted start
- cycle_count  output  CNT_W  RUN cycles of current/last run, saturating

Behaviour:
- Reset (async, active-high) values:
  - FSM = IDLE
  - pc = 0, running = 0, halted = 0, cycle_count = 0
- FSM states: IDLE, RUN, HALT. `running` = (state==RUN); `halted` = (state==HALT). Both are registered state decodes.
- IDLE or HALT with start=1 at edge:
  - pc <= start_addr, cycle_count <= 0, state <= RUN, halted drops same edge.
  - Otherwise pc and cycle_count hold.
- RUN, each edge:
  - cycle_count <= cycle_count+1, saturating at all-ones.
  - The counter increments on the done cycle too.
- RUN next-pc priority, highest first:
  1. done_in=1: state <= HALT, pc holds. Jump inputs are ignored that cycle.
  2. absjump_enable=1: pc <= zero-extended jump_operand. If OFF_W>PC_W, truncate to low PC_W bits.
  3. reljump_enable=1 and (compare_enable=0 or cmp_equal=1): pc <= pc + sign-extended jump_operand, modulo 2^PC_W.
  4. Otherwise pc <= pc+1, modulo 2^PC_W.
- A conditional branch that is not taken (reljump_enable=1, compare_enable=1, cmp_equal=0) advances pc+1.
- absjump_enable and reljump_enable both high: absolute wins.
- compare_enable without reljump_enable: no effect.
- start while in RUN: ignored; no restart.
- Jump/done inputs in IDLE/HALT: ignored; pc holds.
- Latency: one instruction per cycle, no bubbles. Control outputs computed from the instruction at `pc` take effect on the next rising edge.
- Wrap-around:
  - pc=2^PC_W-1 sequential → 0.
  - Relative offset −1 at pc=0 → 2^PC_W-1.
  - Offset 0 is legal: infinite loop on self.
- Reset asserted mid-run: immediate return to reset values; no pending jump survives.
- start held high across a halt: re-entry to RUN on the edge after HALT is entered. Benches pulse start.

Test Plan:
- Reset mid-run: with pc=0x055, cycle_count=7 in RUN, assert reset between edges. Expect pc=0, running=0, halted=0 and cycle_count=0 immediately (asynchronously). Then start, start_addr=0x010: running=1, pc=0x010 after one edge.
- Sequential run: from pc=0x010, three cycles with no requests → pc 0x011, 0x012, 0x013; cycle_count=3. Then done_in=1 → halted=1, running=0, pc stays 0x013, cycle_count=4.
- Relative jumps:
  - At pc=0x020, reljump_enable=1, compare_enable=0, jump_operand=0xFC (−4) → pc=0x01C.
  - At pc=0x000, same operand → pc=0x3FC (wrap).
  - jump_operand=0x05 from 0x3FE → pc=0x003.
- Conditional branch: at pc=0x030 with reljump_enable=1, compare_enable=1, jump_operand=0x08:
  - cmp_equal=0 → pc=0x031.
  - Repeat from 0x030 with cmp_equal=1 → pc=0x038.
- Absolute jump and priorities:
  - absjump_enable=1, jump_operand=0xA7 → pc=0x0A7.
  - absjump_enable=1 and reljump_enable=1 together with operand 0x05 → pc=0x005.
  - done_in=1 together with absjump_enable=1 → HALT, pc unchanged.
- Saturation and ignored inputs:
  - With CNT_W=4, run 20 cycles → cycle_count sticks at 0xF.
  - start pulse during RUN → no pc reload.
  - reljump_enable in HALT → pc unchanged.
